td4_control_unit: RTL and testbench

- Multi-cycle fetch/decode/execute sequencer for the 4-bit CPU.
- Sits directly downstream of the 4-bit program counter: it consumes the counter's Q as the fetch address and produces the counter's load/count enables.
- Also produces the register load enables, the ALU source select and the immediate for the datapath.
- Holds the instruction register and the carry flag.

---
 rtl/td4_control_unit.sv | 160 ++++++++++++++++
 tb/tb_td4_control_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/td4_control_unit.sv
// -----------------------------------------------------------------------------
// td4_control_unit
//
// Fetch/decode/execute sequencer for the TD4 4-bit CPU. Each instruction takes
// three cycles: FETCH latches the ROM word into the instruction register,
// DECODE presents the ALU source select and immediate, and EXEC pulses the
// register / program-counter enables for a single cycle and updates the carry
// flag.
//
// Ports
//   CLK         in   system clock, rising edge
//   RST         in   synchronous active-high reset
//   PC          in   program counter value (fetch address source)
//   ROM_DATA    in   instruction word at ROM_ADDR (asynchronous ROM)
//   ALU_CARRY   in   adder carry for the instruction in EXEC
//   HALT        in   holds the sequencer in FETCH while high
//   ROM_ADDR    out  fetch address, combinationally equal to PC
//   SEL         out  ALU source: 00=A, 01=B, 10=IN port, 11=zero
//   IMM         out  immediate field of the instruction register
//   ENB_LD_A    out  load register A        (EXEC only)
//   ENB_LD_B    out  load register B        (EXEC only)
//   ENB_LD_OUT  out  load output port       (EXEC only)
//   PC_ENB_LD   out  program counter load   (EXEC only, jump taken)
//   PC_ENB_CNT  out  program counter count  (EXEC only, no jump)
//   C_FLAG      out  registered carry flag
//   STATE       out  00=FETCH, 01=DECODE, 10=EXEC
//   INSTR_DONE  out  one-cycle pulse in EXEC
// -----------------------------------------------------------------------------
module td4_control_unit #(
    parameter int OPW = 4,
    parameter int IMW = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [IMW-1:0]       PC,
    input  logic [OPW+IMW-1:0]   ROM_DATA,
    input  logic                 ALU_CARRY,
    input  logic                 HALT,
    output logic [IMW-1:0]       ROM_ADDR,
    output logic [1:0]           SEL,
    output logic [IMW-1:0]       IMM,
    output logic                 ENB_LD_A,
    output logic                 ENB_LD_B,
    output logic                 ENB_LD_OUT,
    output logic                 PC_ENB_LD,
    output logic                 PC_ENB_CNT,
    output logic                 C_FLAG,
    output logic [1:0]           STATE,
    output logic                 INSTR_DONE
);

    localparam int IW = OPW + IMW;

    // The unused encoding is named so the next-state logic can steer out of it.
    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_DECODE = 2'b01,
        ST_EXEC   = 2'b10,
        ST_BAD    = 2'b11
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IW-1:0]    ir;
    logic             c_flag;
    logic [OPW-1:0]   opcode;

    // Instruction decode, independent of sequencing state.
    logic [1:0]       sel_dec;
    logic             ld_a_dec;
    logic             ld_b_dec;
    logic             ld_out_dec;
    logic             jump_dec;

    assign opcode     = ir[IW-1 -: OPW];
    assign ROM_ADDR   = PC;
    assign IMM        = ir[IMW-1:0];
    assign SEL        = sel_dec;
    assign C_FLAG     = c_flag;
    assign STATE      = state;

    // -------------------------------------------------------------------------
    // State, instruction register and carry flag
    // -------------------------------------------------------------------------
    // NOTE: registers are updated with non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_FETCH;
            ir     <= '0;
            c_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_FETCH && !HALT)
                ir <= ROM_DATA;
            // Carry is captured for every opcode, jumps and NOPs included.
            if (state == ST_EXEC)
                c_flag <= ALU_CARRY;
        end
    end

    // -------------------------------------------------------------------------
    // Decode table: opcode -> ALU source and destination
    // -------------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default before the
    // case statement, so no path leaves a signal unassigned and no latch forms.
    always_comb begin
        sel_dec    = 2'b11;
        ld_a_dec   = 1'b0;
        ld_b_dec   = 1'b0;
        ld_out_dec = 1'b0;
        jump_dec   = 1'b0;
        case (opcode)
            4'b0000: begin sel_dec = 2'b00; ld_a_dec   = 1'b1; end  // ADD A,Im
            4'b0001: begin sel_dec = 2'b01; ld_a_dec   = 1'b1; end  // MOV A,B
            4'b0010: begin sel_dec = 2'b10; ld_a_dec   = 1'b1; end  // IN  A
            4'b0011: begin sel_dec = 2'b11; ld_a_dec   = 1'b1; end  // MOV A,Im
            4'b0100: begin sel_dec = 2'b00; ld_b_dec   = 1'b1; end  // MOV B,A
            4'b0101: begin sel_dec = 2'b01; ld_b_dec   = 1'b1; end  // ADD B,Im
            4'b0110: begin sel_dec = 2'b10; ld_b_dec   = 1'b1; end  // IN  B
            4'b0111: begin sel_dec = 2'b11; ld_b_dec   = 1'b1; end  // MOV B,Im
            4'b1001: begin sel_dec = 2'b01; ld_out_dec = 1'b1; end  // OUT B
            4'b1011: begin sel_dec = 2'b11; ld_out_dec = 1'b1; end  // OUT Im
            // JNC looks at the flag from the previous instruction: c_flag is
            // only overwritten at the edge that closes this EXEC cycle.
            4'b1110: begin sel_dec = 2'b11; jump_dec   = ~c_flag; end
            4'b1111: begin sel_dec = 2'b11; jump_dec   = 1'b1;    end
            default: begin sel_dec = 2'b11; end                      // NOP
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequencer: next state and EXEC-only enables
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt  = ST_FETCH;
        ENB_LD_A   = 1'b0;
        ENB_LD_B   = 1'b0;
        ENB_LD_OUT = 1'b0;
        PC_ENB_LD  = 1'b0;
        PC_ENB_CNT = 1'b0;
        INSTR_DONE = 1'b0;
        case (state)
            ST_FETCH:  state_nxt = HALT ? ST_FETCH : ST_DECODE;
            ST_DECODE: state_nxt = ST_EXEC;
            ST_EXEC: begin
                state_nxt  = ST_FETCH;
                ENB_LD_A   = ld_a_dec;
                ENB_LD_B   = ld_b_dec;
                ENB_LD_OUT = ld_out_dec;
                // Load and count are mutually exclusive by construction.
                PC_ENB_LD  = jump_dec;
                PC_ENB_CNT = ~jump_dec;
                INSTR_DONE = 1'b1;
            end
            default:   state_nxt = ST_FETCH;  // recover from 2'b11 quietly
        endcase
    end

endmodule

// File: tb/tb_td4_control_unit.sv
// -----------------------------------------------------------------------------
// tb_td4_control_unit
//
// Directed bench for the TD4 sequencer. The stimulus process issues one
// instruction at a time and pushes the hand-computed EXEC response into a
// queue; a separate monitor pops and compares whenever INSTR_DONE is seen.
// Per-phase state/enable checks are made inline by the stimulus process.
// -----------------------------------------------------------------------------
module tb_td4_control_unit;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] PC;
    logic [7:0] ROM_DATA;
    logic       ALU_CARRY;
    logic       HALT;
    logic [3:0] ROM_ADDR;
    logic [1:0] SEL;
    logic [3:0] IMM;
    logic       ENB_LD_A;
    logic       ENB_LD_B;
    logic       ENB_LD_OUT;
    logic       PC_ENB_LD;
    logic       PC_ENB_CNT;
    logic       C_FLAG;
    logic [1:0] STATE;
    logic       INSTR_DONE;

    td4_control_unit #(.OPW(4), .IMW(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .PC         (PC),
        .ROM_DATA   (ROM_DATA),
        .ALU_CARRY  (ALU_CARRY),
        .HALT       (HALT),
        .ROM_ADDR   (ROM_ADDR),
        .SEL        (SEL),
        .IMM        (IMM),
        .ENB_LD_A   (ENB_LD_A),
        .ENB_LD_B   (ENB_LD_B),
        .ENB_LD_OUT (ENB_LD_OUT),
        .PC_ENB_LD  (PC_ENB_LD),
        .PC_ENB_CNT (PC_ENB_CNT),
        .C_FLAG     (C_FLAG),
        .STATE      (STATE),
        .INSTR_DONE (INSTR_DONE)
    );

    always #5 CLK = ~CLK;

    // Expected EXEC-cycle response.
    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] imm;
        logic       ld_a;
        logic       ld_b;
        logic       ld_out;
        logic       pc_ld;
        logic       pc_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic [3:0] last_imm;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] sel, input logic [3:0] imm,
                                input logic a, input logic b, input logic o,
                                input logic jmp);
        exp_t e;
        e.sel = sel; e.imm = imm; e.ld_a = a; e.ld_b = b; e.ld_out = o;
        e.pc_ld = jmp; e.pc_cnt = ~jmp;
        return e;
    endfunction

    // Monitor: every INSTR_DONE pulse must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (INSTR_DONE === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL exec_unexpected: INSTR_DONE with no pending instruction (t=%0t)", $time);
            end else begin
                exp_t e;
                exp_t got;
                e   = exp_q.pop_front();
                got = {SEL, IMM, ENB_LD_A, ENB_LD_B, ENB_LD_OUT, PC_ENB_LD, PC_ENB_CNT};
                check("exec_response", 16'(got), 16'(e));
            end
        end
    end

    function automatic logic [15:0] enables();
        return {10'd0, ENB_LD_A, ENB_LD_B, ENB_LD_OUT, PC_ENB_LD, PC_ENB_CNT, INSTR_DONE};
    endfunction

    // Issue one instruction starting in FETCH (called 1 time unit after a
    // falling edge). HALT is held high for halt_cycles first.
    task automatic do_instr(input logic [7:0] ins, input logic carry,
                            input int halt_cycles, input logic [3:0] pc_val,
                            input exp_t e);
        ROM_DATA  = ins;
        ALU_CARRY = carry;
        PC        = pc_val;
        #1;
        check("rom_addr", 16'(ROM_ADDR), 16'(pc_val));
        if (halt_cycles > 0) begin
            HALT = 1'b1;
            for (int i = 0; i < halt_cycles; i++) begin
                @(negedge CLK);
                check("halt_state", 16'(STATE), 16'(2'b00));
                check("halt_enables", enables(), 16'd0);
                check("halt_ir_hold", 16'(IMM), 16'(last_imm));
                #1;
            end
        end
        HALT = 1'b0;
        exp_q.push_back(e);
        @(negedge CLK);
        check("decode_state", 16'(STATE), 16'(2'b01));
        check("decode_enables", enables(), 16'd0);
        check("decode_sel_imm", {10'd0, SEL, IMM}, {10'd0, e.sel, e.imm});
        @(negedge CLK);
        check("exec_state", 16'(STATE), 16'(2'b10));
        @(negedge CLK);
        check("post_exec_state", 16'(STATE), 16'(2'b00));
        check("post_exec_enables", enables(), 16'd0);
        check("post_exec_cflag", 16'(C_FLAG), 16'(carry));
        last_imm = e.imm;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; PC = 4'h0; ROM_DATA = 8'h00; ALU_CARRY = 1'b0; HALT = 1'b0;
        last_imm = 4'h0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_state", 16'(STATE), 16'(2'b00));
        check("reset_enables", enables(), 16'd0);
        check("reset_sel_imm", {10'd0, SEL, IMM}, 16'd0);
        check("reset_cflag", 16'(C_FLAG), 16'd0);
        #1;
        RST = 1'b0;

        //        instr  carry halt pc     sel    imm   A     B     OUT   jump
        do_instr(8'h35, 1'b0, 0, 4'h0, mk(2'b11, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0)); // MOV A,5
        do_instr(8'hF7, 1'b0, 0, 4'h1, mk(2'b11, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1)); // JMP 7
        do_instr(8'h02, 1'b1, 0, 4'h7, mk(2'b00, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0)); // ADD A,2 C=1
        do_instr(8'hE3, 1'b0, 0, 4'h8, mk(2'b11, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0)); // JNC 3 not taken
        do_instr(8'h01, 1'b0, 0, 4'h9, mk(2'b00, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0)); // ADD A,1 C=0
        do_instr(8'hE3, 1'b0, 0, 4'hA, mk(2'b11, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1)); // JNC 3 taken
        do_instr(8'h57, 1'b0, 5, 4'h3, mk(2'b01, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0)); // ADD B,7 after HALT
        do_instr(8'h8C, 1'b0, 0, 4'h4, mk(2'b11, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0)); // NOP 8
        do_instr(8'hA1, 1'b1, 0, 4'h5, mk(2'b11, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0)); // NOP A, C=1
        do_instr(8'hC2, 1'b0, 0, 4'h6, mk(2'b11, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0)); // NOP C
        do_instr(8'hD3, 1'b0, 0, 4'h7, mk(2'b11, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0)); // NOP D
        do_instr(8'h94, 1'b0, 0, 4'h8, mk(2'b01, 4'h4, 1'b0, 1'b0, 1'b1, 1'b0)); // OUT B
        do_instr(8'hB6, 1'b0, 0, 4'h9, mk(2'b11, 4'h6, 1'b0, 1'b0, 1'b1, 1'b0)); // OUT 6
        do_instr(8'h10, 1'b0, 0, 4'hA, mk(2'b01, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0)); // MOV A,B
        do_instr(8'h20, 1'b0, 0, 4'hB, mk(2'b10, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0)); // IN A
        do_instr(8'h40, 1'b0, 0, 4'hC, mk(2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0)); // MOV B,A
        do_instr(8'h6F, 1'b0, 0, 4'hD, mk(2'b10, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0)); // IN B
        do_instr(8'h79, 1'b1, 0, 4'hE, mk(2'b11, 4'h9, 1'b0, 1'b1, 1'b0, 1'b0)); // MOV B,9 C=1
        do_instr(8'hFF, 1'b0, 0, 4'hF, mk(2'b11, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1)); // JMP F (C was 1)

        // Reset while in DECODE: set C_FLAG first, then abort the next one.
        do_instr(8'h0E, 1'b1, 0, 4'hF, mk(2'b00, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0)); // ADD A,E C=1
        ROM_DATA = 8'h35; ALU_CARRY = 1'b1; HALT = 1'b0;
        @(negedge CLK);
        check("abort_decode_state", 16'(STATE), 16'(2'b01));
        #1;
        RST = 1'b1;
        @(negedge CLK);
        check("abort_reset_state", 16'(STATE), 16'(2'b00));
        check("abort_reset_cflag", 16'(C_FLAG), 16'd0);
        check("abort_reset_enables", enables(), 16'd0);
        check("abort_reset_sel_imm", {10'd0, SEL, IMM}, 16'd0);
        #1;
        RST = 1'b0; HALT = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check("abort_no_exec", enables(), 16'd0);
        end

        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
